// File: rtl/types.sv
// Shared flit and node-id types for the routing tree and its system-flit logic.
package types;

  typedef logic [7:0] node_id_t;
  typedef logic [1:0] flit_type_t;
  typedef logic [3:0] sys_header_t;

  localparam node_id_t   BROADCAST_ID = 8'hFF;

  localparam flit_type_t DATA   = 2'd0;
  localparam flit_type_t SYSTEM = 2'd1;

  localparam sys_header_t S_PARENT_REQUEST_FROM_NEIGHBOR = 4'd1;
  localparam sys_header_t S_PARENT_ACK_FROM_NEIGHBOR     = 4'd2;
  localparam sys_header_t S_JOIN_REQUEST                 = 4'd3;
  localparam sys_header_t S_JOIN_ACK                     = 4'd4;

  typedef struct packed {
    node_id_t parent_id;
    node_id_t random_child_id;
  } join_request_t;

  typedef struct packed {
    node_id_t child_id;
    node_id_t random_child_id;
  } join_ack_t;

  typedef union packed {
    join_request_t join_request;
    join_ack_t     join_ack;
  } system_body_t;

  typedef struct packed {
    sys_header_t  header;
    system_body_t body;
  } system_t;

  typedef struct packed {
    flit_type_t flittype;
    node_id_t   src_id;
    node_id_t   dst_id;
    system_t    system;
  } flit_t;

endpackage

// File: rtl/join_sequencer.sv
// Join controller for a non-root node: sends parent/join requests, snoops acks,
// retries on timeout and owns the temporal, parent and assigned node ids.
module join_sequencer #(
  parameter int unsigned ACK_TIMEOUT = 1024,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           rejoin,
  input  logic           is_root,
  input  types::node_id_t random_id,
  input  logic           rx_valid,
  input  types::flit_t   rx_flit,
  output logic           tx_valid,
  input  logic           tx_ready,
  output types::flit_t   tx_flit,
  output types::node_id_t temporal_id,
  output logic           parent_valid,
  output types::node_id_t parent_node_id,
  output logic           this_node_valid,
  output types::node_id_t this_node_id,
  output logic           busy,
  output logic           failed
);

  localparam int unsigned TimerW = $clog2(ACK_TIMEOUT);
  localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StSendPreq = 3'd1;
  localparam logic [2:0] StWaitPack = 3'd2;
  localparam logic [2:0] StSendJreq = 3'd3;
  localparam logic [2:0] StWaitJack = 3'd4;
  localparam logic [2:0] StJoined   = 3'd5;
  localparam logic [2:0] StFailed   = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [RetryW-1:0] retry_q, retry_d;
  types::node_id_t   temporal_q, temporal_d;
  types::node_id_t   parent_id_q, parent_id_d;
  types::node_id_t   this_id_q, this_id_d;
  logic              parent_valid_q, parent_valid_d;
  logic              this_valid_q, this_valid_d;
  logic              tx_valid_q, tx_valid_d;
  types::flit_t      tx_flit_q, tx_flit_d;

  logic pack_match, jack_match, timeout, begin_attempt, timeout_hit;

  assign pack_match = rx_valid && (rx_flit.flittype == types::SYSTEM) &&
                      (rx_flit.system.header == types::S_PARENT_ACK_FROM_NEIGHBOR) &&
                      (rx_flit.dst_id == temporal_q);
  assign jack_match = rx_valid && (rx_flit.flittype == types::SYSTEM) &&
                      (rx_flit.system.header == types::S_JOIN_ACK) &&
                      (rx_flit.system.body.join_ack.random_child_id == temporal_q);
  assign timeout    = (timer_q == TimerW'(ACK_TIMEOUT - 1));

  always_comb begin
    state_d        = state_q;
    timer_d        = '0;
    retry_d        = retry_q;
    temporal_d     = temporal_q;
    parent_id_d    = parent_id_q;
    parent_valid_d = parent_valid_q;
    this_id_d      = this_id_q;
    this_valid_d   = this_valid_q;
    begin_attempt  = 1'b0;
    timeout_hit    = 1'b0;

    case (state_q)
      StIdle, StFailed: begin
        if (start) begin_attempt = 1'b1;
      end
      StSendPreq: begin
        if (tx_ready) state_d = StWaitPack;
      end
      StWaitPack: begin
        // A matching ack takes priority over a timeout in the same cycle.
        if (pack_match) begin
          parent_id_d    = rx_flit.src_id;
          parent_valid_d = 1'b1;
          state_d        = StSendJreq;
        end else if (timeout) begin
          timeout_hit = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StSendJreq: begin
        if (tx_ready) state_d = StWaitJack;
      end
      StWaitJack: begin
        if (jack_match) begin
          this_id_d    = rx_flit.system.body.join_ack.child_id;
          this_valid_d = 1'b1;
          state_d      = StJoined;
        end else if (timeout) begin
          timeout_hit = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StJoined: begin
        if (rejoin) begin
          this_valid_d   = 1'b0;
          parent_valid_d = 1'b0;
          begin_attempt  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (begin_attempt) begin
      if (is_root) begin
        this_valid_d   = 1'b1;
        this_id_d      = '0;
        parent_valid_d = 1'b0;
        state_d        = StJoined;
      end else begin
        temporal_d = random_id;
        retry_d    = '0;
        state_d    = StSendPreq;
      end
    end

    if (timeout_hit) begin
      parent_valid_d = 1'b0;
      if (retry_q == RetryW'(MAX_RETRY)) begin
        state_d = StFailed;
      end else begin
        retry_d    = retry_q + 1'b1;
        temporal_d = random_id;
        state_d    = StSendPreq;
      end
    end
  end

  // Flit is built from next-state ids so it is registered and stable for the whole SEND state.
  always_comb begin
    tx_valid_d = (state_d == StSendPreq) || (state_d == StSendJreq);
    tx_flit_d  = '0;
    if (state_d == StSendPreq) begin
      tx_flit_d.flittype      = types::SYSTEM;
      tx_flit_d.src_id        = temporal_d;
      tx_flit_d.dst_id        = types::BROADCAST_ID;
      tx_flit_d.system.header = types::S_PARENT_REQUEST_FROM_NEIGHBOR;
    end else if (state_d == StSendJreq) begin
      tx_flit_d.flittype                                 = types::SYSTEM;
      tx_flit_d.src_id                                   = temporal_d;
      tx_flit_d.dst_id                                   = parent_id_d;
      tx_flit_d.system.header                            = types::S_JOIN_REQUEST;
      tx_flit_d.system.body.join_request.parent_id       = parent_id_d;
      tx_flit_d.system.body.join_request.random_child_id = temporal_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      timer_q        <= '0;
      retry_q        <= '0;
      temporal_q     <= '0;
      parent_id_q    <= '0;
      parent_valid_q <= 1'b0;
      this_id_q      <= '0;
      this_valid_q   <= 1'b0;
      tx_valid_q     <= 1'b0;
      tx_flit_q      <= '0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      retry_q        <= retry_d;
      temporal_q     <= temporal_d;
      parent_id_q    <= parent_id_d;
      parent_valid_q <= parent_valid_d;
      this_id_q      <= this_id_d;
      this_valid_q   <= this_valid_d;
      tx_valid_q     <= tx_valid_d;
      tx_flit_q      <= tx_flit_d;
    end
  end

  assign tx_valid        = tx_valid_q;
  assign tx_flit         = tx_flit_q;
  assign temporal_id     = temporal_q;
  assign parent_valid    = parent_valid_q;
  assign parent_node_id  = parent_id_q;
  assign this_node_valid = this_valid_q;
  assign this_node_id    = this_id_q;
  assign busy            = (state_q == StSendPreq) || (state_q == StWaitPack) ||
                           (state_q == StSendJreq) || (state_q == StWaitJack);
  assign failed          = (state_q == StFailed);

endmodule

// File: doc/join_sequencer.md
# join_sequencer

Per-node join controller that drives a non-root node from power-up to a joined state in the routing tree. It generates the parent-request and join-request system flits, snoops incoming system flits for the matching parent-ack and join-ack, and applies timeouts and retries. It owns the temporal (random) id, the parent id and this node's id that the system-flit combinational logic and the routing table consume. It sits beside the packet controller's system-flit path and injects into the same TX port through a valid/ready handshake.

## Interface
- ACK_TIMEOUT, 1024: cycles to wait for an ack in a WAIT state; must be ≥ 2.
- MAX_RETRY, 3: number of timeouts tolerated before FAILED; total attempts = MAX_RETRY+1.
- clk  in  1  clock; everything is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  pulse; begins a join from IDLE or FAILED; ignored in every other state.
- rejoin  in  1  pulse; in JOINED, drops the membership and restarts the join.
- is_root  in  1  static strap; root nodes join immediately as id 0.
- random_id  in  $bits(types::node_id_t)  fresh random id, sampled when an attempt starts.
- rx_valid  in  1  a received flit is present this cycle; always accepted, no backpressure.
- rx_flit  in  types::flit_t  received flit.
- tx_valid  out  1  an outgoing system flit is presented.
- tx_ready  in  1  injection port accepts tx_flit this cycle.
- tx_flit  out  types::flit_t  outgoing flit.
- temporal_id  out  node_id_t  current random id.
- parent_valid / parent_node_id  out  1 / node_id_t  chosen parent.
- this_node_valid / this_node_id  out  1 / node_id_t  assigned id.
- busy  out  1  high in SEND_PREQ, WAIT_PACK, SEND_JREQ and WAIT_JACK.
- failed  out  1  high in FAILED.

## Operation
- States: IDLE, SEND_PREQ, WAIT_PACK, SEND_JREQ, WAIT_JACK, JOINED, FAILED.
- IDLE, start:
  - If is_root: go to JOINED with this_node_valid=1, this_node_id=0 and parent_valid=0.
  - Otherwise: latch temporal_id=random_id, clear retry_cnt, go to SEND_PREQ.
- SEND_PREQ: tx_valid=1 with a parent-request flit.
  - Flit fields: flittype=SYSTEM, src_id=temporal_id, dst_id=types::BROADCAST_ID, system.header=S_PARENT_REQUEST_FROM_NEIGHBOR. All other fields are 0.
  - When tx_ready=1, go to WAIT_PACK.
- WAIT_PACK: a match is rx_valid, flittype=SYSTEM, system.header=S_PARENT_ACK_FROM_NEIGHBOR and dst_id==temporal_id.
  - On the first match: latch parent_node_id=src_id, set parent_valid=1, go to SEND_JREQ.
  - Later acks are ignored.
- SEND_JREQ: tx_valid=1 with a join-request flit.
  - Flit fields: SYSTEM, src_id=temporal_id, dst_id=parent_node_id, system.header=S_JOIN_REQUEST, join_request.parent_id=parent_node_id, join_request.random_child_id=temporal_id.
  - On handshake, go to WAIT_JACK.
- WAIT_JACK: a match is SYSTEM, S_JOIN_ACK and join_ack.random_child_id==temporal_id.
  - On a match: this_node_id=join_ack.child_id, this_node_valid=1, go to JOINED.
- Timeout in either WAIT state:
  - If retry_cnt==MAX_RETRY: go to FAILED and clear parent_valid.
  - Otherwise: retry_cnt+1, clear parent_valid, re-latch temporal_id=random_id, go to SEND_PREQ.
- JOINED: holds. rejoin clears this_node_valid and parent_valid and behaves as start from IDLE.
- FAILED: holds. start behaves as from IDLE (retry_cnt cleared).
- Non-matching rx flits are ignored in every state.
- tx_flit and tx_valid are registered. They are stable while tx_valid=1 and tx_ready=0. tx_valid=0 outside the SEND states.

## Timing
- Reset value: state=IDLE, and every output is 0 (tx_valid, tx_flit, temporal_id, parent_*, this_node_*, busy, failed). retry_cnt and timer are also 0.
- Reset mid-operation aborts immediately with no flit emitted afterwards. A pending tx_valid drops asynchronously.
- start sampled at edge T: state=SEND_PREQ and tx_valid=1 from T+1.
- Handshake at edge T: state=WAIT_* from T+1, timer=0.
- Timer:
  - Increments each cycle in WAIT states.
  - Timeout is evaluated when timer==ACK_TIMEOUT-1, so the exit is ACK_TIMEOUT cycles after WAIT entry.
  - Width is $clog2(ACK_TIMEOUT).
- A matching ack and a timeout in the same cycle: the ack wins.
- A matching rx at edge T: new state and latched ids are visible at T+1.
- In the SEND states, rx is not monitored. Acks are only accepted in WAIT states.
- start and rejoin asserted together: rejoin takes effect only in JOINED, and start only in IDLE or FAILED.

## Test plan
- Non-root, random_id=0x2A, start.
  - Expected: broadcast PREQ with src=0x2A.
  - Apply tx_ready 3 cycles later; tx_flit is held stable throughout.
  - Then ack from 0x05 with dst=0x2A → JREQ dst=0x05, parent_id=0x05, random_child_id=0x2A.
  - Then JACK child_id=0x07 → this_node_id=0x07 and this_node_valid=1 next cycle.
- is_root=1, start → JOINED next cycle, this_node_id=0, parent_valid=0, no tx_valid ever.
- ACK_TIMEOUT=8, MAX_RETRY=2, no acks, tx_ready=1.
  - Expected: three PREQs, each with a fresh random_id, spaced by the 8-cycle timeouts.
  - After the third timeout: failed=1, busy=0.
  - Then start → a new PREQ.
- In WAIT_PACK, send acks with dst≠temporal_id, then two valid acks from 0x03 and 0x04 → parent=0x03. The second ack is ignored.
- Matching JACK in the exact timeout cycle → JOINED, not a retry. Also check JACK with a wrong random_child_id → ignored.
- Assert rst during SEND_JREQ with tx_ready=0 → all outputs 0 immediately, IDLE. A subsequent start repeats the full join.
